pipe_ctrl_unit: RTL and testbench

//  Pipelined successor to the single-cycle control decoder. Decodes the ID-stage opcode into the control

---
 rtl/pipe_ctrl_unit.sv | 169 ++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// Pipelined control unit: decodes ID, carries control through EX/MEM/WB,
// detects load-use stalls and resolves beq in MEM with a flush.
module pipe_ctrl_unit #(
  parameter int REG_AW   = 5,
  parameter bit EN_ITYPE = 1'b1,
  parameter int STALL_CW = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [6:0]        id_opcode,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              mem_zero,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              if_id_flush,
  output logic              pc_src,
  output logic              ex_alu_src,
  output logic [1:0]        ex_alu_op,
  output logic              mem_read,
  output logic              mem_write,
  output logic              mem_branch,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] mem_rd,
  output logic [REG_AW-1:0] wb_rd,
  output logic              illegal_op,
  output logic [STALL_CW-1:0] stall_cnt
);

  typedef struct packed {
    logic       alu_src;
    logic [1:0] alu_op;
    logic       mr;
    logic       mw;
    logic       br;
    logic       rw;
    logic       m2r;
  } ctrl_t;

  ctrl_t dec;
  ctrl_t ex_q;
  logic  use1, use2, ill;
  logic  is_r, is_ld, is_sd, is_beq, is_i;
  logic  stall, flush;
  logic  mem_rw, mem_m2r;

  // ID-stage decode of the opcode into the control bundle
  always_comb begin
    dec    = '0;
    use1   = 1'b0;
    use2   = 1'b0;
    ill    = 1'b0;
    is_r   = id_opcode == 7'b0110011;
    is_ld  = id_opcode == 7'b0000011;
    is_sd  = id_opcode == 7'b0100011;
    is_beq = id_opcode == 7'b1100011;
    is_i   = EN_ITYPE && (id_opcode == 7'b0010011);
    if (id_valid) begin
      unique case (1'b1)
        is_r: begin
          dec.alu_op = 2'b10;
          dec.rw     = 1'b1;
          use1       = 1'b1;
          use2       = 1'b1;
        end
        is_ld: begin
          dec.alu_src = 1'b1;
          dec.m2r     = 1'b1;
          dec.rw      = 1'b1;
          dec.mr      = 1'b1;
          use1        = 1'b1;
        end
        is_sd: begin
          dec.alu_src = 1'b1;
          dec.mw      = 1'b1;
          use1        = 1'b1;
          use2        = 1'b1;
        end
        is_beq: begin
          dec.br     = 1'b1;
          dec.alu_op = 2'b01;
          use1       = 1'b1;
          use2       = 1'b1;
        end
        is_i: begin
          dec.alu_src = 1'b1;
          dec.rw      = 1'b1;
          dec.alu_op  = 2'b11;
          use1        = 1'b1;
        end
        default: ill = 1'b1;
      endcase
    end
  end

  // Hazard detection and fetch-side control; a taken branch overrides a stall
  always_comb begin
    flush = mem_branch & mem_zero;
    stall = ex_q.mr && (ex_rd != '0) &&
            ((use1 && (ex_rd == id_rs1)) ||
             (use2 && (ex_rd == id_rs2)));
    pc_src      = flush;
    if_id_flush = flush;
    pc_write    = flush | ~stall;
    if_id_write = flush | ~stall;
  end

  // ID/EX register: decode, bubble on stall, cleared on flush
  always_ff @(posedge clk) begin
    if (rst || flush || stall) begin
      ex_q       <= '0;
      ex_rd      <= '0;
      illegal_op <= 1'b0;
    end else begin
      ex_q       <= dec;
      ex_rd      <= id_valid ? id_rd : '0;
      illegal_op <= ill;
    end
  end

  // EX/MEM register: cleared on flush, otherwise follows ID/EX
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_branch <= 1'b0;
      mem_rw     <= 1'b0;
      mem_m2r    <= 1'b0;
      mem_rd     <= '0;
    end else begin
      mem_read   <= ex_q.mr;
      mem_write  <= ex_q.mw;
      mem_branch <= ex_q.br;
      mem_rw     <= ex_q.rw;
      mem_m2r    <= ex_q.m2r;
      mem_rd     <= ex_rd;
    end
  end

  // MEM/WB register: always advances, the branch itself leaves MEM normally
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
      wb_rd         <= '0;
    end else begin
      wb_reg_write  <= mem_rw;
      wb_mem_to_reg <= mem_m2r;
      wb_rd         <= mem_rd;
    end
  end

  // Saturating count of cycles lost to load-use stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (stall && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign ex_alu_src = ex_q.alu_src;
  assign ex_alu_op  = ex_q.alu_op;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Bench for pipe_ctrl_unit: two configurations driven in lockstep and
// compared against an instruction-level pipeline model.
module tb_pipe_ctrl_unit;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_SD  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [6:0] id_opcode;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       mem_zero;

  logic       pc_write [2];
  logic       if_id_write [2];
  logic       if_id_flush [2];
  logic       pc_src [2];
  logic       ex_alu_src [2];
  logic [1:0] ex_alu_op [2];
  logic       mem_read [2];
  logic       mem_write [2];
  logic       mem_branch [2];
  logic       wb_reg_write [2];
  logic       wb_mem_to_reg [2];
  logic [4:0] ex_rd [2];
  logic [4:0] mem_rd [2];
  logic [4:0] wb_rd [2];
  logic       illegal_op [2];
  logic [7:0] sc0;
  logic [1:0] sc1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit u_dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .mem_zero(mem_zero),
    .pc_write(pc_write[0]), .if_id_write(if_id_write[0]),
    .if_id_flush(if_id_flush[0]), .pc_src(pc_src[0]),
    .ex_alu_src(ex_alu_src[0]), .ex_alu_op(ex_alu_op[0]),
    .mem_read(mem_read[0]), .mem_write(mem_write[0]),
    .mem_branch(mem_branch[0]), .wb_reg_write(wb_reg_write[0]),
    .wb_mem_to_reg(wb_mem_to_reg[0]), .ex_rd(ex_rd[0]),
    .mem_rd(mem_rd[0]), .wb_rd(wb_rd[0]),
    .illegal_op(illegal_op[0]), .stall_cnt(sc0)
  );

  pipe_ctrl_unit #(.EN_ITYPE(1'b0), .STALL_CW(2)) u_dut1 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .mem_zero(mem_zero),
    .pc_write(pc_write[1]), .if_id_write(if_id_write[1]),
    .if_id_flush(if_id_flush[1]), .pc_src(pc_src[1]),
    .ex_alu_src(ex_alu_src[1]), .ex_alu_op(ex_alu_op[1]),
    .mem_read(mem_read[1]), .mem_write(mem_write[1]),
    .mem_branch(mem_branch[1]), .wb_reg_write(wb_reg_write[1]),
    .wb_mem_to_reg(wb_mem_to_reg[1]), .ex_rd(ex_rd[1]),
    .mem_rd(mem_rd[1]), .wb_rd(wb_rd[1]),
    .illegal_op(illegal_op[1]), .stall_cnt(sc1)
  );

  typedef struct packed {
    logic       as;
    logic [1:0] op;
    logic       mr, mw, br, rw, m2r, ill, u1, u2;
  } dc_t;

  typedef struct {
    bit         live;
    logic [6:0] op;
    logic [4:0] rd;
  } ins_t;

  localparam ins_t EMPTY = '{live: 1'b0, op: 7'd0, rd: 5'd0};

  ins_t pex [2];
  ins_t pmem [2];
  ins_t pwb [2];
  int   cnt [2];
  int   cmax [2] = '{255, 3};
  bit   eni [2] = '{1'b1, 1'b0};

  task automatic chk(input string tag, input int unsigned got,
                     input int unsigned exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic dc_t dec(input logic [6:0] o, input bit en);
    dc_t c = '0;
    if (o == OP_R) begin
      c.op = 2'd2; c.rw = 1; c.u1 = 1; c.u2 = 1;
    end else if (o == OP_LD) begin
      c.as = 1; c.m2r = 1; c.rw = 1; c.mr = 1; c.u1 = 1;
    end else if (o == OP_SD) begin
      c.as = 1; c.mw = 1; c.u1 = 1; c.u2 = 1;
    end else if (o == OP_BEQ) begin
      c.br = 1; c.op = 2'd1; c.u1 = 1; c.u2 = 1;
    end else if (en && o == OP_I) begin
      c.as = 1; c.rw = 1; c.op = 2'd3; c.u1 = 1;
    end else begin
      c.ill = 1;
    end
    return c;
  endfunction

  function automatic dc_t ctl(input ins_t i, input bit en);
    return i.live ? dec(i.op, en) : '0;
  endfunction

  function automatic bit m_flush(input int d);
    return ctl(pmem[d], eni[d]).br && mem_zero;
  endfunction

  function automatic bit m_stall(input int d);
    dc_t e = ctl(pex[d], eni[d]);
    dc_t i = id_valid ? dec(id_opcode, eni[d]) : '0;
    return e.mr && pex[d].rd != 0 &&
           ((i.u1 && pex[d].rd == id_rs1) ||
            (i.u2 && pex[d].rd == id_rs2));
  endfunction

  task automatic check_dut(input int d);
    dc_t e = ctl(pex[d], eni[d]);
    dc_t m = ctl(pmem[d], eni[d]);
    dc_t w = ctl(pwb[d], eni[d]);
    bit  f = m_flush(d);
    bit  s = m_stall(d);
    int  sc = (d == 0) ? int'(sc0) : int'(sc1);
    chk($sformatf("ex_alu_src%0d", d), ex_alu_src[d], e.as);
    chk($sformatf("ex_alu_op%0d", d), ex_alu_op[d], e.op);
    chk($sformatf("illegal_op%0d", d), illegal_op[d], e.ill);
    chk($sformatf("ex_rd%0d", d), ex_rd[d], pex[d].rd);
    chk($sformatf("mem_read%0d", d), mem_read[d], m.mr);
    chk($sformatf("mem_write%0d", d), mem_write[d], m.mw);
    chk($sformatf("mem_branch%0d", d), mem_branch[d], m.br);
    chk($sformatf("mem_rd%0d", d), mem_rd[d], pmem[d].rd);
    chk($sformatf("wb_reg_write%0d", d), wb_reg_write[d], w.rw);
    chk($sformatf("wb_mem_to_reg%0d", d), wb_mem_to_reg[d], w.m2r);
    chk($sformatf("wb_rd%0d", d), wb_rd[d], pwb[d].rd);
    chk($sformatf("pc_src%0d", d), pc_src[d], f);
    chk($sformatf("if_id_flush%0d", d), if_id_flush[d], f);
    chk($sformatf("pc_write%0d", d), pc_write[d], f | !s);
    chk($sformatf("if_id_write%0d", d), if_id_write[d], f | !s);
    chk($sformatf("stall_cnt%0d", d), sc, cnt[d]);
  endtask

  task automatic cyc(input bit v, input logic [6:0] op,
                     input logic [4:0] r1, input logic [4:0] r2,
                     input logic [4:0] rd, input bit z, input bit r);
    ins_t nex [2];
    ins_t nmem [2];
    ins_t nwb [2];
    int   ncnt [2];
    rst = r; id_valid = v; id_opcode = op;
    id_rs1 = r1; id_rs2 = r2; id_rd = rd; mem_zero = z;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_dut(d);
      ncnt[d] = cnt[d];
      nwb[d]  = pmem[d];
      nmem[d] = pex[d];
      nex[d]  = v ? '{live: 1'b1, op: op, rd: rd} : EMPTY;
      if (r) begin
        nex[d] = EMPTY; nmem[d] = EMPTY; nwb[d] = EMPTY; ncnt[d] = 0;
      end else if (m_flush(d)) begin
        nex[d] = EMPTY; nmem[d] = EMPTY;
      end else if (m_stall(d)) begin
        nex[d] = EMPTY;
        if (ncnt[d] < cmax[d]) ncnt[d]++;
      end
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      pex[d] = nex[d]; pmem[d] = nmem[d];
      pwb[d] = nwb[d]; cnt[d] = ncnt[d];
    end
    #1;
  endtask

  task automatic nop();
    cyc(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
    cyc(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1);
  endtask

  logic [6:0] ops [7];
  int         sat_exp [5] = '{1, 2, 3, 3, 3};

  initial begin
    ops = '{OP_R, OP_LD, OP_SD, OP_BEQ, OP_I, OP_BAD, 7'd0};
    rst = 1'b1; id_valid = 1'b0; id_opcode = '0;
    id_rs1 = '0; id_rs2 = '0; id_rd = '0; mem_zero = 1'b0;
    for (int d = 0; d < 2; d++) begin
      pex[d] = EMPTY; pmem[d] = EMPTY; pwb[d] = EMPTY; cnt[d] = 0;
    end
    @(posedge clk); #1;
    do_reset();

    // R-type x3 <= x1,x2 through the pipe
    cyc(1'b1, OP_R, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0);
    chk("t1_ex_alu_op", ex_alu_op[0], 2);
    chk("t1_ex_rd", ex_rd[0], 3);
    nop(); nop();
    chk("t1_wb_reg_write", wb_reg_write[0], 1);
    chk("t1_wb_rd", wb_rd[0], 3);
    chk("t1_wb_m2r", wb_mem_to_reg[0], 0);

    // load-use on rs2, held R retried after the bubble
    cyc(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
    cyc(1'b1, OP_R, 5'd1, 5'd5, 5'd6, 1'b0, 1'b0);
    chk("t2_stall_cnt", sc0, 1);
    chk("t2_bubble_rd", ex_rd[0], 0);
    cyc(1'b1, OP_R, 5'd1, 5'd5, 5'd6, 1'b0, 1'b0);
    chk("t2_r_in_ex", ex_rd[0], 6);

    // ld x0 never stalls; sd on rs2 does
    cyc(1'b1, OP_LD, 5'd1, 5'd0, 5'd0, 1'b0, 1'b0);
    cyc(1'b1, OP_R, 5'd0, 5'd0, 5'd7, 1'b0, 1'b0);
    chk("t3_x0_nostall", sc0, 1);
    cyc(1'b1, OP_LD, 5'd1, 5'd0, 5'd5, 1'b0, 1'b0);
    cyc(1'b1, OP_SD, 5'd2, 5'd5, 5'd0, 1'b0, 1'b0);
    chk("t3_sd_stall", sc0, 2);
    cyc(1'b1, OP_SD, 5'd2, 5'd5, 5'd0, 1'b0, 1'b0);

    // taken beq with a load-use pair behind it: flush wins
    cyc(1'b1, OP_BEQ, 5'd1, 5'd2, 5'd0, 1'b0, 1'b0);
    cyc(1'b1, OP_LD, 5'd1, 5'd0, 5'd4, 1'b0, 1'b0);
    cyc(1'b1, OP_R, 5'd4, 5'd4, 5'd8, 1'b1, 1'b0);
    chk("t4_flush_ex_rd", ex_rd[0], 0);
    chk("t4_flush_mem_rd", mem_rd[0], 0);
    chk("t4_flush_mem_read", mem_read[0], 0);
    chk("t4_flush_cnt", sc0, 2);

    // illegal opcodes, and OP-IMM on the EN_ITYPE=0 instance
    cyc(1'b1, OP_BAD, 5'd1, 5'd2, 5'd9, 1'b0, 1'b0);
    chk("t5_illegal", illegal_op[0], 1);
    chk("t5_alu_src", ex_alu_src[0], 0);
    cyc(1'b1, OP_I, 5'd1, 5'd0, 5'd9, 1'b0, 1'b0);
    chk("t5_itype_ok", illegal_op[0], 0);
    chk("t5_itype_ill", illegal_op[1], 1);
    chk("t5_itype_op1", ex_alu_op[1], 0);

    // five stalls on the 2-bit counter, then reset mid-stream
    do_reset();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, OP_LD, 5'd2, 5'd0, 5'd1, 1'b0, 1'b0);
      cyc(1'b1, OP_R, 5'd1, 5'd3, 5'd4, 1'b0, 1'b0);
      chk("t6_sat", sc1, sat_exp[i]);
      cyc(1'b1, OP_R, 5'd1, 5'd3, 5'd4, 1'b0, 1'b0);
    end
    cyc(1'b1, OP_LD, 5'd2, 5'd0, 5'd1, 1'b0, 1'b1);
    chk("t6_rst_wb", wb_reg_write[0], 0);
    chk("t6_rst_mem", mem_rd[0], 0);
    chk("t6_rst_cnt", sc1, 0);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      cyc(($urandom % 8) != 0, ops[$urandom_range(0, 6)] ^
          (($urandom % 7 == 0) ? 7'($urandom) : 7'd0),
          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          5'($urandom_range(0, 3)), 1'($urandom),
          ($urandom % 64) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
